// File: rtl/apb_pkg.sv
// Shared types for the APB requester: FSM state encoding, default bus widths
// and the packed response record returned on the rsp_* stream.
package apb_pkg;

  localparam int APB_ADDR_W = 32;
  localparam int APB_DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } apb_state_e;

  typedef struct packed {
    logic [APB_DATA_W-1:0] rdata;
    logic                  err;
    logic                  timeout;
  } apb_rsp_t;

endpackage

// File: rtl/apb_requester_if.sv
// Bundles the command stream, response stream and APB bus of the requester;
// master is the requester's view, slave is the view of everything around it.
interface apb_requester_if
  import apb_pkg::*;
#(
  parameter int ADDR_W = APB_ADDR_W,
  parameter int DATA_W = APB_DATA_W
);

  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_wr;
  logic [ADDR_W-1:0] cmd_addr;
  logic [DATA_W-1:0] cmd_wdata;

  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_err;
  logic              rsp_timeout;

  logic              p_sel;
  logic              p_en;
  logic              p_wr;
  logic [ADDR_W-1:0] p_addr;
  logic [DATA_W-1:0] pw_data;
  logic [DATA_W-1:0] pr_data;
  logic              p_ready;
  logic              pslverr;

  modport master (
    input  cmd_valid, cmd_wr, cmd_addr, cmd_wdata,
    input  rsp_ready,
    input  pr_data, p_ready, pslverr,
    output cmd_ready,
    output rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
    output p_sel, p_en, p_wr, p_addr, pw_data
  );

  modport slave (
    output cmd_valid, cmd_wr, cmd_addr, cmd_wdata,
    output rsp_ready,
    output pr_data, p_ready, pslverr,
    input  cmd_ready,
    input  rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
    input  p_sel, p_en, p_wr, p_addr, pw_data
  );

endinterface

// File: rtl/apb_requester.sv
// APB initiator: turns one valid/ready command into a SETUP/ACCESS transfer and
// returns read data and error status on a valid/ready response stream.
module apb_requester
  import apb_pkg::*;
#(
  parameter int ADDR_W  = APB_ADDR_W,
  parameter int DATA_W  = APB_DATA_W,
  parameter int TIMEOUT = 1024
) (
  input  logic             pclk,
  input  logic             prst,
  apb_requester_if.master  bus
);

  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  apb_state_e        state, state_nx;
  logic              p_sel_q, p_sel_d;
  logic              p_en_q, p_en_d;
  logic              p_wr_q, p_wr_d;
  logic [ADDR_W-1:0] p_addr_q, p_addr_d;
  logic [DATA_W-1:0] pw_data_q, pw_data_d;
  logic              rsp_valid_q, rsp_valid_d;
  apb_rsp_t          rsp_q, rsp_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              timeout_hit;

  // With TIMEOUT=0 the counter still runs but can never trigger an abort.
  assign timeout_hit = (TIMEOUT != 0) && (cnt_q == CNT_LAST);

  always_ff @(posedge pclk) begin
    if (prst) begin
      state       <= IDLE;
      p_sel_q     <= 1'b0;
      p_en_q      <= 1'b0;
      p_wr_q      <= 1'b0;
      p_addr_q    <= '0;
      pw_data_q   <= '0;
      rsp_valid_q <= 1'b0;
      rsp_q       <= '0;
      cnt_q       <= '0;
    end else begin
      state       <= state_nx;
      p_sel_q     <= p_sel_d;
      p_en_q      <= p_en_d;
      p_wr_q      <= p_wr_d;
      p_addr_q    <= p_addr_d;
      pw_data_q   <= pw_data_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_q       <= rsp_d;
      cnt_q       <= cnt_d;
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (bus.cmd_valid) state_nx = SETUP;
      SETUP:   state_nx = ACCESS;
      ACCESS:  if (bus.p_ready || timeout_hit) state_nx = RESP;
      RESP:    if (bus.rsp_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Next values of the registered outputs; everything holds unless a state acts on it.
  always_comb begin
    p_sel_d     = p_sel_q;
    p_en_d      = p_en_q;
    p_wr_d      = p_wr_q;
    p_addr_d    = p_addr_q;
    pw_data_d   = pw_data_q;
    rsp_valid_d = rsp_valid_q;
    rsp_d       = rsp_q;
    cnt_d       = cnt_q;
    unique case (state)
      IDLE: begin
        if (bus.cmd_valid) begin
          p_wr_d    = bus.cmd_wr;
          p_addr_d  = bus.cmd_addr;
          pw_data_d = bus.cmd_wdata;
          p_sel_d   = 1'b1;
          p_en_d    = 1'b0;
        end
      end
      SETUP: begin
        p_en_d = 1'b1;
        cnt_d  = '0;
      end
      ACCESS: begin
        if (bus.p_ready) begin
          rsp_d.rdata   = p_wr_q ? '0 : APB_DATA_W'(bus.pr_data);
          rsp_d.err     = bus.pslverr;
          rsp_d.timeout = 1'b0;
          p_sel_d       = 1'b0;
          p_en_d        = 1'b0;
          rsp_valid_d   = 1'b1;
        end else if (timeout_hit) begin
          rsp_d.rdata   = '0;
          rsp_d.err     = 1'b1;
          rsp_d.timeout = 1'b1;
          p_sel_d       = 1'b0;
          p_en_d        = 1'b0;
          rsp_valid_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RESP: begin
        if (bus.rsp_ready) rsp_valid_d = 1'b0;
      end
      default: ;
    endcase
  end

  assign bus.cmd_ready   = (state == IDLE);
  assign bus.p_sel       = p_sel_q;
  assign bus.p_en        = p_en_q;
  assign bus.p_wr        = p_wr_q;
  assign bus.p_addr      = p_addr_q;
  assign bus.pw_data     = pw_data_q;
  assign bus.rsp_valid   = rsp_valid_q;
  assign bus.rsp_rdata   = DATA_W'(rsp_q.rdata);
  assign bus.rsp_err     = rsp_q.err;
  assign bus.rsp_timeout = rsp_q.timeout;

endmodule

// File: tb/tb_apb_requester.sv
// Directed bench for apb_requester: a table of single transfers against a
// scripted APB slave, plus backpressure and mid-transfer reset sequences.
module tb_apb_requester;
  import apb_pkg::*;

  localparam int AW = APB_ADDR_W;
  localparam int DW = APB_DATA_W;
  localparam int TO = 16;

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] prdata;
    int          waits;
    logic        err_wait;
    logic        err_rdy;
    logic [31:0] exp_rdata;
    logic        exp_err;
    logic        exp_to;
    int          exp_lat;
  } vec_t;

  logic pclk = 1'b0;
  logic prst;
  int   errors = 0;
  int   checks = 0;

  apb_requester_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  apb_requester #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
    .pclk (pclk),
    .prst (prst),
    .bus  (bus)
  );

  always #5 pclk = ~pclk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge pclk);
    #1;
  endtask

  task automatic idle_inputs;
    bus.cmd_valid = 1'b0;
    bus.cmd_wr    = 1'b0;
    bus.cmd_addr  = '0;
    bus.cmd_wdata = '0;
    bus.rsp_ready = 1'b1;
    bus.pr_data   = '0;
    bus.p_ready   = 1'b0;
    bus.pslverr   = 1'b0;
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    int   cyc;
    int   w;
    logic done;
    bus.cmd_valid = 1'b1;
    bus.cmd_wr    = v.wr;
    bus.cmd_addr  = v.addr;
    bus.cmd_wdata = v.wdata;
    bus.rsp_ready = 1'b1;
    chk({tag, ".cmd_ready_idle"}, 32'(bus.cmd_ready), 32'd1);
    tick;
    bus.cmd_valid = 1'b0;
    chk({tag, ".psel_setup"}, 32'(bus.p_sel), 32'd1);
    chk({tag, ".pen_setup"}, 32'(bus.p_en), 32'd0);
    chk({tag, ".cmd_ready_busy"}, 32'(bus.cmd_ready), 32'd0);
    tick;
    cyc = 2;
    chk({tag, ".pen_access"}, 32'(bus.p_en), 32'd1);
    chk({tag, ".pwr"}, 32'(bus.p_wr), 32'(v.wr));
    chk({tag, ".paddr"}, bus.p_addr, v.addr);
    chk({tag, ".pwdata"}, bus.pw_data, v.wdata);
    w = 0;
    done = 1'b0;
    while (!done && cyc < 40) begin
      if (w == v.waits) begin
        bus.p_ready = 1'b1;
        bus.pr_data = v.prdata;
        bus.pslverr = v.err_rdy;
      end else begin
        bus.p_ready = 1'b0;
        bus.pr_data = ~v.prdata;
        bus.pslverr = v.err_wait;
      end
      tick;
      cyc++;
      w++;
      if (bus.rsp_valid) done = 1'b1;
      else chk({tag, ".hold"}, {bus.p_sel, bus.p_en, bus.p_addr[29:0]}, {2'b11, v.addr[29:0]});
    end
    bus.p_ready = 1'b0;
    bus.pslverr = 1'b0;
    chk({tag, ".latency"}, 32'(cyc), 32'(v.exp_lat));
    chk({tag, ".rsp_valid"}, 32'(bus.rsp_valid), 32'd1);
    chk({tag, ".psel_pen_low"}, {30'd0, bus.p_sel, bus.p_en}, 32'd0);
    chk({tag, ".rdata"}, bus.rsp_rdata, v.exp_rdata);
    chk({tag, ".err"}, 32'(bus.rsp_err), 32'(v.exp_err));
    chk({tag, ".timeout"}, 32'(bus.rsp_timeout), 32'(v.exp_to));
    tick;
    chk({tag, ".rsp_done"}, 32'(bus.rsp_valid), 32'd0);
    chk({tag, ".back_idle"}, 32'(bus.cmd_ready), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[7];
    int   n;
    vecs[0] = '{1'b1, 32'h0, 32'h0000_0778, 32'h0,         0,  1'b0, 1'b0, 32'h0,         1'b0, 1'b0, 3};
    vecs[1] = '{1'b0, 32'h3, 32'h0,         32'h3a3a_3a3a, 3,  1'b0, 1'b0, 32'h3a3a_3a3a, 1'b0, 1'b0, 6};
    vecs[2] = '{1'b1, 32'h2, 32'h0000_00aa, 32'h0,         0,  1'b0, 1'b1, 32'h0,         1'b1, 1'b0, 3};
    vecs[3] = '{1'b0, 32'h5, 32'h1111_2222, 32'h1234_5678, 2,  1'b1, 1'b0, 32'h1234_5678, 1'b0, 1'b0, 5};
    vecs[4] = '{1'b0, 32'h7, 32'h0,         32'hdead_beef, 1,  1'b0, 1'b1, 32'hdead_beef, 1'b1, 1'b0, 4};
    vecs[5] = '{1'b0, 32'h9, 32'h0,         32'h5555_aaaa, 99, 1'b1, 1'b0, 32'h0,         1'b1, 1'b1, 18};
    vecs[6] = '{1'b1, 32'h40, 32'hcafe_0015, 32'h7777_7777, 15, 1'b1, 1'b0, 32'h0,        1'b0, 1'b0, 18};

    idle_inputs();
    prst = 1'b1;
    tick;
    tick;
    prst = 1'b0;
    chk("rst.ctrl", {26'd0, bus.p_sel, bus.p_en, bus.p_wr, bus.rsp_valid, bus.rsp_err, bus.rsp_timeout}, 32'd0);
    chk("rst.paddr", bus.p_addr, 32'd0);
    chk("rst.pwdata", bus.pw_data, 32'd0);
    chk("rst.rdata", bus.rsp_rdata, 32'd0);
    chk("rst.cmd_ready", 32'(bus.cmd_ready), 32'd1);

    for (int i = 0; i < 7; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

    // Backpressure: response held for 10 cycles while a second command waits.
    bus.rsp_ready = 1'b0;
    bus.p_ready   = 1'b1;
    bus.pr_data   = 32'h0bad_cafe;
    bus.cmd_valid = 1'b1;
    bus.cmd_wr    = 1'b1;
    bus.cmd_addr  = 32'h10;
    bus.cmd_wdata = 32'haaaa_0001;
    tick;
    n = 1;
    while (!bus.rsp_valid && n < 10) begin
      tick;
      n++;
    end
    chk("bp.latency", 32'(n), 32'd3);
    bus.cmd_wr    = 1'b0;
    bus.cmd_addr  = 32'h14;
    bus.cmd_wdata = 32'hbbbb_0002;
    for (int k = 0; k < 10; k++) begin
      tick;
      chk("bp.stall_flags", {28'd0, bus.cmd_ready, bus.rsp_valid, bus.rsp_err, bus.rsp_timeout}, 32'h4);
      chk("bp.stall_rdata", bus.rsp_rdata, 32'd0);
    end
    bus.rsp_ready = 1'b1;
    tick;
    chk("bp.reidle", {30'd0, bus.cmd_ready, bus.rsp_valid}, 32'h2);
    tick;
    bus.cmd_valid = 1'b0;
    chk("bp.next_accept", {30'd0, bus.p_sel, bus.cmd_ready}, 32'h2);
    chk("bp.next_addr", bus.p_addr, 32'h14);
    chk("bp.next_wdata", bus.pw_data, 32'hbbbb_0002);
    tick;
    chk("bp.next_pen", 32'(bus.p_en), 32'd1);
    tick;
    chk("bp.next_rsp", 32'(bus.rsp_valid), 32'd1);
    chk("bp.next_rdata", bus.rsp_rdata, 32'h0bad_cafe);
    bus.p_ready = 1'b0;
    tick;
    chk("bp.next_done", 32'(bus.cmd_ready), 32'd1);

    // Reset during an ACCESS wait state drops the transfer silently.
    bus.cmd_valid = 1'b1;
    bus.cmd_wr    = 1'b0;
    bus.cmd_addr  = 32'h3;
    bus.cmd_wdata = 32'h0;
    tick;
    bus.cmd_valid = 1'b0;
    tick;
    tick;
    chk("rmid.in_access", {30'd0, bus.p_sel, bus.p_en}, 32'h3);
    prst = 1'b1;
    tick;
    prst = 1'b0;
    chk("rmid.flags", {28'd0, bus.p_sel, bus.p_en, bus.rsp_valid, bus.cmd_ready}, 32'h1);
    chk("rmid.paddr", bus.p_addr, 32'd0);
    bus.p_ready = 1'b1;
    bus.pslverr = 1'b1;
    tick;
    chk("rmid.ignore_pready", {30'd0, bus.rsp_valid, bus.cmd_ready}, 32'h1);
    bus.p_ready = 1'b0;
    bus.pslverr = 1'b0;
    run_vec('{1'b1, 32'h2, 32'hf6f6_f6f6, 32'h0, 0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 3}, "rmid.write");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/apb_requester.md
Name: apb_requester

Overview:
- APB initiator that converts a simple valid/ready command stream into APB SETUP/ACCESS transfers.
- Returns read data and error status on a valid/ready response stream.
- Sits between on-chip control logic and the UART APB slave (topp), driving the pclk-domain APB bus that the slave responds to.
- Includes an ACCESS-phase timeout so that a stuck p_ready cannot hang the requester.

Parameters:
- ADDR_W, 32, width of p_addr and cmd_addr
- DATA_W, 32, width of pw_data, pr_data, cmd_wdata and rsp_rdata
- TIMEOUT, 1024, number of ACCESS cycles allowed without p_ready before the transfer is aborted; 0 disables the timeout

Ports:
- pclk  in  1  clock; all logic is on the rising edge
- prst  in  1  synchronous, active-high reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  command accepted when cmd_valid && cmd_ready
- cmd_wr  in  1  1 = write, 0 = read
- cmd_addr  in  ADDR_W  transfer address
- cmd_wdata  in  DATA_W  write data; ignored for reads
- rsp_valid  out  1  response present
- rsp_ready  in  1  response consumed when rsp_valid && rsp_ready
- rsp_rdata  out  DATA_W  read data; 0 for writes and for aborted transfers
- rsp_err  out  1  pslverr was seen, or the transfer timed out
- rsp_timeout  out  1  transfer was aborted by the timeout
- p_sel  out  1  APB select
- p_en  out  1  APB enable
- p_wr  out  1  APB write
- p_addr  out  ADDR_W  APB address
- pw_data  out  DATA_W  APB write data
- pr_data  in  DATA_W  APB read data
- p_ready  in  1  APB ready
- pslverr  in  1  APB slave error; sampled only when p_ready=1 in ACCESS

Behaviour:
- Reset (prst=1 at an edge):
  - state=IDLE.
  - p_sel, p_en, p_wr, rsp_valid, rsp_err and rsp_timeout are 0.
  - p_addr, pw_data and rsp_rdata are 0.
  - Timeout counter is 0.
  - A reset mid-transfer or with a response pending drops everything with no response issued; p_sel and p_en are low from the cycle after the reset edge.
- FSM states: IDLE, SETUP, ACCESS, RESP. All outputs are registered except cmd_ready, which is (state==IDLE).
- IDLE:
  - On cmd_valid, register cmd_wr, cmd_addr and cmd_wdata into p_wr, p_addr and pw_data.
  - Set p_sel=1 and p_en=0, then go to SETUP.
  - pw_data is loaded even for reads.
- SETUP: lasts exactly one cycle. Set p_en=1, clear the timeout counter, go to ACCESS.
- ACCESS:
  - p_sel, p_en, p_wr, p_addr and pw_data are held stable.
  - If p_ready=1:
    - rsp_rdata = pr_data for reads, 0 for writes.
    - rsp_err = pslverr, rsp_timeout = 0.
    - Set p_sel=0, p_en=0, rsp_valid=1, go to RESP.
  - Else if TIMEOUT≠0 and the counter equals TIMEOUT-1:
    - Abort: p_sel=0, p_en=0.
    - rsp_rdata=0, rsp_err=1, rsp_timeout=1, rsp_valid=1, go to RESP.
  - Otherwise increment the counter.
- RESP:
  - rsp_* are held stable until rsp_ready.
  - On rsp_ready, clear rsp_valid and go to IDLE.
  - No new command is accepted while in RESP.
- Latency and throughput:
  - Zero-wait-state slave: command accepted at edge N; SETUP in cycle N+1; ACCESS in cycle N+2; rsp_valid high from cycle N+3.
  - Each wait state adds one cycle.
  - Throughput is one transfer per 4 cycles minimum when rsp_ready is tied high.
- Between transfers, p_addr, pw_data and p_wr keep their last values; only p_sel and p_en return low.
- p_ready and pslverr are ignored outside ACCESS.

Decomposition:
- Package apb_pkg holds:
  - typedef enum apb_state_e {IDLE, SETUP, ACCESS, RESP}
  - default ADDR_W/DATA_W localparams
  - a packed apb_rsp_t struct {rdata, err, timeout}
- The bench and the UART top share apb_pkg.
- Single module; the timeout counter is inline, with no sub-module.

Test Plan:
- Write, zero wait states: cmd_wr=1, addr=0x0, wdata=0x0000_0778, slave p_ready=1.
  - Required: p_sel rises at N+1, p_en at N+2.
  - Required: rsp_valid at N+3 with rsp_err=0 and rsp_rdata=0.
- Read, 3 wait states: addr=0x3; slave holds p_ready=0 for 3 ACCESS cycles, then p_ready=1 with pr_data=0x3a3a_3a3a.
  - Required: p_addr stable throughout; rsp_valid at N+6 with rsp_rdata=0x3a3a_3a3a.
- Slave error: write addr=0x2 with pslverr=1 and p_ready=1.
  - Required: rsp_err=1, rsp_timeout=0.
  - Required: a pslverr=1 driven while p_ready=0 in an earlier cycle has no effect.
- Timeout, TIMEOUT=16: p_ready stuck at 0.
  - Required: exactly 16 ACCESS cycles, then p_sel=p_en=0.
  - Required: rsp_err=1, rsp_timeout=1, rsp_rdata=0.
- Backpressure: rsp_ready=0 for 10 cycles with cmd_valid held high.
  - Required: cmd_ready=0 and rsp_* stable throughout.
  - Required: on rsp_ready=1, IDLE is re-entered and the next command is accepted the following cycle.
- Reset mid-ACCESS: assert prst for 1 cycle during a wait state.
  - Required: next cycle p_sel=p_en=0, rsp_valid=0, cmd_ready=1.
  - Required: the following write of 0xf6f6_f6f6 to addr 0x2 completes normally.
